sram_access_arbiter: RTL and testbench

//  Shares the 32x256 dual-port SRAM (one write port W0, one read port R0) between the

---
 rtl/sram_access_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Arbitrates the dual-port SRAM macro between the spectrometer datapath and the
// management-SoC Wishbone slave, with independent round-robin grants per port.
module sram_access_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          AW        = 8,
  parameter int          DW        = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          dp_w_valid,
  output logic          dp_w_ready,
  input  logic [AW-1:0] dp_w_addr,
  input  logic [DW-1:0] dp_w_data,
  input  logic          dp_r_valid,
  output logic          dp_r_ready,
  input  logic [AW-1:0] dp_r_addr,
  output logic          dp_rd_valid,
  output logic [DW-1:0] dp_rd_data,
  output logic          R0_clk,
  output logic          R0_en,
  output logic [AW-1:0] R0_addr,
  input  logic [DW-1:0] R0_data,
  output logic          W0_clk,
  output logic          W0_en,
  output logic [AW-1:0] W0_addr,
  output logic [DW-1:0] W0_data
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    ACK
  } wb_state_t;

  wb_state_t     state;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;
  logic          wb_sel_full;
  logic          wb_drop;
  logic          wb_drop_now;
  logic          wb_hit;
  logic          wb_w_req;
  logic          wb_r_req;

  logic          w_prio_wb;
  logic          r_prio_wb;
  logic          w_grant_dp;
  logic          w_grant_wb;
  logic [AW-1:0] w_addr_sel;
  logic          r_pick_dp;
  logic          r_pick_wb;
  logic [AW-1:0] r_addr_sel;
  logic          rw_hazard;
  logic          r_grant_dp;
  logic          r_grant_wb;

  logic          s1_valid;
  logic          s1_wb;
  logic          s1_byp;
  logic [DW-1:0] s1_byp_data;
  logic [DW-1:0] rd_word;

  logic          unused_adr_bits;

  assign R0_clk          = wb_clk_i;
  assign W0_clk          = wb_clk_i;
  assign unused_adr_bits = ^wbs_adr_i[1:0];

  assign wb_hit      = (wbs_adr_i[31:10] == BASE_ADDR[31:10]);
  assign wb_w_req    = (state == WR_REQ) && wb_sel_full;
  assign wb_r_req    = (state == RD_REQ);
  assign wb_drop_now = wb_drop || !wbs_cyc_i;

  // Grants are combinational; a read that collides with this cycle's write is held back one cycle.
  always_comb begin
    w_grant_dp = dp_w_valid && (!wb_w_req || !w_prio_wb);
    w_grant_wb = wb_w_req && (!dp_w_valid || w_prio_wb);
    w_addr_sel = w_grant_dp ? dp_w_addr : wb_addr;
    r_pick_dp  = dp_r_valid && (!wb_r_req || !r_prio_wb);
    r_pick_wb  = wb_r_req && (!dp_r_valid || r_prio_wb);
    r_addr_sel = r_pick_dp ? dp_r_addr : wb_addr;
    rw_hazard  = (w_grant_dp || w_grant_wb) && (r_pick_dp || r_pick_wb) &&
                 (r_addr_sel == w_addr_sel);
    r_grant_dp = r_pick_dp && !rw_hazard;
    r_grant_wb = r_pick_wb && !rw_hazard;
  end

  assign dp_w_ready = w_grant_dp;
  assign dp_r_ready = r_grant_dp;
  assign R0_en      = r_grant_dp || r_grant_wb;
  assign R0_addr    = r_addr_sel;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      W0_en     <= 1'b0;
      W0_addr   <= '0;
      W0_data   <= '0;
      w_prio_wb <= 1'b0;
      r_prio_wb <= 1'b0;
    end else begin
      W0_en <= w_grant_dp || w_grant_wb;
      if (w_grant_dp || w_grant_wb) begin
        W0_addr <= w_addr_sel;
        W0_data <= w_grant_dp ? dp_w_data : wb_wdata;
      end
      if (w_grant_dp) begin
        w_prio_wb <= 1'b1;
      end else if (w_grant_wb) begin
        w_prio_wb <= 1'b0;
      end
      if (r_grant_dp) begin
        r_prio_wb <= 1'b1;
      end else if (r_grant_wb) begin
        r_prio_wb <= 1'b0;
      end
    end
  end

  // The macro reads old contents when a registered write lands on the same edge,
  // so such reads take the in-flight write data instead.
  assign rd_word = s1_byp ? s1_byp_data : R0_data;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      s1_valid    <= 1'b0;
      s1_wb       <= 1'b0;
      s1_byp      <= 1'b0;
      s1_byp_data <= '0;
      dp_rd_valid <= 1'b0;
      dp_rd_data  <= '0;
    end else begin
      s1_valid    <= R0_en;
      s1_wb       <= r_grant_wb;
      s1_byp      <= W0_en && (W0_addr == R0_addr);
      s1_byp_data <= W0_data;
      dp_rd_valid <= s1_valid && !s1_wb;
      if (s1_valid && !s1_wb) begin
        dp_rd_data <= rd_word;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      wb_addr     <= '0;
      wb_wdata    <= '0;
      wb_sel_full <= 1'b0;
      wb_drop     <= 1'b0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wbs_ack_o <= 1'b0;
          if (wbs_cyc_i && wbs_stb_i) begin
            wb_addr     <= wbs_adr_i[AW+1:2];
            wb_wdata    <= wbs_dat_i;
            wb_sel_full <= (wbs_sel_i == 4'hF);
            wb_drop     <= 1'b0;
            wbs_dat_o   <= '0;
            if (!wb_hit) begin
              state     <= ACK;
              wbs_ack_o <= 1'b1;
            end else if (wbs_we_i) begin
              state <= WR_REQ;
            end else begin
              state <= RD_REQ;
            end
          end
        end
        // Partial-word writes are acknowledged without touching the macro (no byte mask).
        WR_REQ: begin
          wb_drop <= wb_drop_now;
          if (!wb_sel_full || w_grant_wb) begin
            state     <= ACK;
            wbs_ack_o <= !wb_drop_now;
          end
        end
        RD_REQ: begin
          wb_drop <= wb_drop_now;
          if (r_grant_wb) begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          wb_drop   <= wb_drop_now;
          wbs_dat_o <= rd_word;
          state     <= ACK;
          wbs_ack_o <= !wb_drop_now;
        end
        ACK: begin
          wbs_ack_o <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter: directed scenarios plus randomized
// datapath traffic checked against a word-level memory model.
module tb_sram_access_arbiter;

  logic        wb_clk_i;
  logic        wb_rst_ni;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        dp_w_valid;
  logic        dp_w_ready;
  logic [7:0]  dp_w_addr;
  logic [31:0] dp_w_data;
  logic        dp_r_valid;
  logic        dp_r_ready;
  logic [7:0]  dp_r_addr;
  logic        dp_rd_valid;
  logic [31:0] dp_rd_data;
  logic        R0_clk;
  logic        R0_en;
  logic [7:0]  R0_addr;
  bit   [31:0] R0_data;
  logic        W0_clk;
  logic        W0_en;
  logic [7:0]  W0_addr;
  logic [31:0] W0_data;

  int cmp_count;
  int err_count;
  int cycle_no;

  bit [31:0] sram    [256];
  bit [31:0] ref_mem [256];

  bit rdy_log [20];
  bit ren_log [20];
  bit wen_log [20];

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_exp_t;

  sram_access_arbiter dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .dp_w_valid  (dp_w_valid),
    .dp_w_ready  (dp_w_ready),
    .dp_w_addr   (dp_w_addr),
    .dp_w_data   (dp_w_data),
    .dp_r_valid  (dp_r_valid),
    .dp_r_ready  (dp_r_ready),
    .dp_r_addr   (dp_r_addr),
    .dp_rd_valid (dp_rd_valid),
    .dp_rd_data  (dp_rd_data),
    .R0_clk      (R0_clk),
    .R0_en       (R0_en),
    .R0_addr     (R0_addr),
    .R0_data     (R0_data),
    .W0_clk      (W0_clk),
    .W0_en       (W0_en),
    .W0_addr     (W0_addr),
    .W0_data     (W0_data)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cycle_no++;

  // SRAM macro model: reads registered, old data returned on a same-edge write.
  always @(posedge W0_clk) begin
    if (W0_en) sram[W0_addr] <= W0_data;
  end

  always @(posedge R0_clk) begin
    if (R0_en) R0_data <= sram[R0_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int lat, output logic [31:0] rdata,
                          output bit timed_out);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    lat       = 0;
    rdata     = '0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      rdy_log[i] = dp_w_ready;
      ren_log[i] = R0_en;
      wen_log[i] = W0_en;
      if (wbs_ack_o) begin
        lat       = i;
        rdata     = wbs_dat_o;
        timed_out = 1'b0;
        break;
      end
      @(negedge wb_clk_i);
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic test_reset;
    wb_rst_ni  = 1'b0;
    wbs_cyc_i  = 1'b0;
    wbs_stb_i  = 1'b0;
    wbs_we_i   = 1'b0;
    wbs_sel_i  = 4'h0;
    wbs_adr_i  = '0;
    wbs_dat_i  = '0;
    dp_w_valid = 1'b0;
    dp_w_addr  = '0;
    dp_w_data  = '0;
    dp_r_valid = 1'b0;
    dp_r_addr  = '0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    #1;
    cmp_count++;
    if ({wbs_ack_o, dp_rd_valid, W0_en, R0_en, dp_w_ready, dp_r_ready} !== 6'b0) begin
      err_count++;
      $display("[TB] FAIL reset_flags: got ack=%b rdv=%b w0en=%b r0en=%b wrdy=%b rrdy=%b want all 0",
               wbs_ack_o, dp_rd_valid, W0_en, R0_en, dp_w_ready, dp_r_ready);
    end
    cmp_count++;
    if ({wbs_dat_o, dp_rd_data, W0_data, W0_addr} !== 104'b0) begin
      err_count++;
      $display("[TB] FAIL reset_data: got dat_o=%h rd_data=%h w0_data=%h w0_addr=%h want 0",
               wbs_dat_o, dp_rd_data, W0_data, W0_addr);
    end
  endtask

  task automatic test_dp_write_wb_read;
    int lat;
    logic [31:0] rd;
    bit to;
    @(negedge wb_clk_i);
    dp_w_valid = 1'b1;
    dp_w_addr  = 8'h10;
    dp_w_data  = 32'hA5A5_0001;
    #1;
    cmp_count++;
    if (dp_w_ready !== 1'b1) begin
      err_count++;
      $display("[TB] FAIL dp_write_lone_ready: got %b want 1", dp_w_ready);
    end
    ref_mem[8'h10] = 32'hA5A5_0001;
    @(negedge wb_clk_i);
    dp_w_valid = 1'b0;
    wb_cycle(1'b0, 32'h3000_0040, 32'h0, 4'hF, lat, rd, to);
    cmp_count++;
    if (to || lat !== 3) begin
      err_count++;
      $display("[TB] FAIL wb_read_latency: got %0d (timeout=%b) want 3", lat, to);
    end
    cmp_count++;
    if (rd !== 32'hA5A5_0001) begin
      err_count++;
      $display("[TB] FAIL wb_read_data: got %h want a5a50001", rd);
    end
  endtask

  task automatic test_starvation;
    int lat;
    logic [31:0] rd;
    bit to;
    int lows;
    int low_at;
    @(negedge wb_clk_i);
    dp_w_valid = 1'b1;
    dp_w_addr  = 8'h30;
    dp_w_data  = 32'h1234_5678;
    wb_cycle(1'b1, 32'h3000_0014, 32'h0BAD_F00D, 4'hF, lat, rd, to);
    dp_w_valid = 1'b0;
    lows   = 0;
    low_at = -1;
    for (int i = 0; i <= lat; i++) begin
      if (!rdy_log[i]) begin
        lows++;
        if (low_at < 0) low_at = i;
      end
    end
    cmp_count++;
    if (to || lat > 3) begin
      err_count++;
      $display("[TB] FAIL starve_wb_ack: got latency %0d (timeout=%b) want <= 3", lat, to);
    end
    cmp_count++;
    if (lows !== 1 || low_at < 1 || low_at > 2) begin
      err_count++;
      $display("[TB] FAIL starve_dp_ready_low: got %0d low cycles first at %0d want 1 at 1..2",
               lows, low_at);
    end
    ref_mem[8'h05] = 32'h0BAD_F00D;
    ref_mem[8'h30] = 32'h1234_5678;
    wb_cycle(1'b0, 32'h3000_0014, 32'h0, 4'hF, lat, rd, to);
    cmp_count++;
    if (to || rd !== ref_mem[8'h05]) begin
      err_count++;
      $display("[TB] FAIL starve_wb_readback: got %h (timeout=%b) want %h", rd, to, ref_mem[8'h05]);
    end
  endtask

  task automatic test_hazard;
    int issue_cycle;
    int seen_at;
    logic [31:0] seen_data;
    @(negedge wb_clk_i);
    dp_w_valid = 1'b1;
    dp_w_addr  = 8'h20;
    dp_w_data  = 32'hDEAD_BEEF;
    dp_r_valid = 1'b1;
    dp_r_addr  = 8'h20;
    #1;
    cmp_count++;
    if (dp_w_ready !== 1'b1 || dp_r_ready !== 1'b0) begin
      err_count++;
      $display("[TB] FAIL hazard_same_cycle: got wrdy=%b rrdy=%b want wrdy=1 rrdy=0",
               dp_w_ready, dp_r_ready);
    end
    ref_mem[8'h20] = 32'hDEAD_BEEF;
    @(negedge wb_clk_i);
    dp_w_valid = 1'b0;
    #1;
    issue_cycle = cycle_no;
    cmp_count++;
    if (dp_r_ready !== 1'b1) begin
      err_count++;
      $display("[TB] FAIL hazard_next_cycle: got rrdy=%b want 1", dp_r_ready);
    end
    seen_at   = -1;
    seen_data = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      dp_r_valid = 1'b0;
      #1;
      if (dp_rd_valid && seen_at < 0) begin
        seen_at   = cycle_no - issue_cycle;
        seen_data = dp_rd_data;
      end
    end
    cmp_count++;
    if (seen_at !== 2 || seen_data !== 32'hDEAD_BEEF) begin
      err_count++;
      $display("[TB] FAIL hazard_read_return: got data %h at +%0d want deadbeef at +2",
               seen_data, seen_at);
    end
  endtask

  task automatic test_miss;
    int lat;
    logic [31:0] rd;
    bit to;
    bit any_ren;
    wb_cycle(1'b0, 32'h3000_0400, 32'h0, 4'hF, lat, rd, to);
    any_ren = 1'b0;
    for (int i = 0; i <= lat; i++) any_ren |= ren_log[i];
    cmp_count++;
    if (to || lat !== 1 || rd !== 32'h0) begin
      err_count++;
      $display("[TB] FAIL miss_ack: got latency %0d data %h (timeout=%b) want latency 1 data 0",
               lat, rd, to);
    end
    cmp_count++;
    if (any_ren !== 1'b0) begin
      err_count++;
      $display("[TB] FAIL miss_r0_en: got R0_en pulse=%b want 0", any_ren);
    end
  endtask

  task automatic test_partial_write;
    int lat;
    logic [31:0] rd;
    bit to;
    bit any_wen;
    wb_cycle(1'b1, 32'h3000_0020, 32'h1111_2222, 4'hF, lat, rd, to);
    ref_mem[8'h08] = 32'h1111_2222;
    cmp_count++;
    if (to || lat !== 2) begin
      err_count++;
      $display("[TB] FAIL wb_write_latency: got %0d (timeout=%b) want 2", lat, to);
    end
    wb_cycle(1'b1, 32'h3000_0020, 32'hFFFF_0000, 4'h3, lat, rd, to);
    any_wen = 1'b0;
    for (int i = 0; i <= lat; i++) any_wen |= wen_log[i];
    cmp_count++;
    if (to || any_wen !== 1'b0) begin
      err_count++;
      $display("[TB] FAIL partial_write_no_w0: got W0_en pulse=%b (timeout=%b) want 0 and ack",
               any_wen, to);
    end
    wb_cycle(1'b0, 32'h3000_0020, 32'h0, 4'hF, lat, rd, to);
    cmp_count++;
    if (to || rd !== ref_mem[8'h08]) begin
      err_count++;
      $display("[TB] FAIL partial_write_readback: got %h (timeout=%b) want %h",
               rd, to, ref_mem[8'h08]);
    end
  endtask

  task automatic test_reset_mid_read;
    int lat;
    int bad;
    logic [31:0] rd;
    bit to;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_0040;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    #1;
    wb_rst_ni = 1'b0;
    #1;
    cmp_count++;
    if (wbs_ack_o !== 1'b0 || dp_rd_valid !== 1'b0) begin
      err_count++;
      $display("[TB] FAIL reset_async_clear: got ack=%b rdv=%b want 0 0", wbs_ack_o, dp_rd_valid);
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge wb_clk_i);
      #1;
      if (wbs_ack_o || dp_rd_valid) bad++;
    end
    cmp_count++;
    if (bad !== 0) begin
      err_count++;
      $display("[TB] FAIL reset_no_stale_response: got %0d cycles with ack/rd_valid want 0", bad);
    end
    wb_cycle(1'b0, 32'h3000_0040, 32'h0, 4'hF, lat, rd, to);
    cmp_count++;
    if (to || lat !== 3 || rd !== ref_mem[8'h10]) begin
      err_count++;
      $display("[TB] FAIL reset_then_read: got latency %0d data %h (timeout=%b) want 3 %h",
               lat, rd, to, ref_mem[8'h10]);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] rd;
    logic [31:0] wdat;
    logic [7:0] word;
    bit to;
    for (int k = 0; k < 4; k++) begin
      word = 8'($urandom_range(128, 255));
      wdat = $urandom;
      wb_cycle(1'b1, 32'h3000_0000 + {22'd0, word, 2'b00}, wdat, 4'hF, lat, rd, to);
      ref_mem[word] = wdat;
      cmp_count++;
      if (to || lat !== 2) begin
        err_count++;
        $display("[TB] FAIL b2b_write_latency[%0d]: got %0d (timeout=%b) want 2", k, lat, to);
      end
      wb_cycle(1'b0, 32'h3000_0000 + {22'd0, word, 2'b00}, 32'h0, 4'hF, lat, rd, to);
      cmp_count++;
      if (to || lat !== 3 || rd !== ref_mem[word]) begin
        err_count++;
        $display("[TB] FAIL b2b_read[%0d]: got latency %0d data %h (timeout=%b) want 3 %h",
                 k, lat, rd, to, ref_mem[word]);
      end
    end
  endtask

  task automatic test_random_dp;
    rd_exp_t q[$];
    bit wv;
    bit rv;
    bit exp_wr;
    bit exp_rr;
    logic [7:0] wa;
    logic [7:0] ra;
    logic [31:0] wd;
    wv = 1'b0;
    rv = 1'b0;
    wa = '0;
    ra = '0;
    wd = '0;
    for (int i = 0; i < 303; i++) begin
      @(negedge wb_clk_i);
      if (i < 300) begin
        if (!wv) begin
          wv = ($urandom_range(0, 9) < 6);
          wa = 8'h40 + 8'($urandom_range(0, 7));
          wd = $urandom;
        end
        if (!rv) begin
          rv = ($urandom_range(0, 9) < 6);
          ra = 8'h40 + 8'($urandom_range(0, 7));
        end
      end else begin
        wv = 1'b0;
        rv = 1'b0;
      end
      dp_w_valid = wv;
      dp_w_addr  = wa;
      dp_w_data  = wd;
      dp_r_valid = rv;
      dp_r_addr  = ra;
      #1;
      exp_wr = wv;
      exp_rr = rv && !(wv && wa == ra);
      cmp_count++;
      if (dp_w_ready !== exp_wr || dp_r_ready !== exp_rr) begin
        err_count++;
        $display("[TB] FAIL rand_ready[%0d]: got wrdy=%b rrdy=%b want wrdy=%b rrdy=%b",
                 i, dp_w_ready, dp_r_ready, exp_wr, exp_rr);
      end
      cmp_count++;
      if (q.size() > 0 && q[0].due == cycle_no) begin
        if (dp_rd_valid !== 1'b1 || dp_rd_data !== q[0].data) begin
          err_count++;
          $display("[TB] FAIL rand_rd_data[%0d]: got valid=%b data=%h want valid=1 data=%h",
                   i, dp_rd_valid, dp_rd_data, q[0].data);
        end
        void'(q.pop_front());
      end else if (dp_rd_valid !== 1'b0) begin
        err_count++;
        $display("[TB] FAIL rand_rd_spurious[%0d]: got valid=%b want 0", i, dp_rd_valid);
      end
      if (exp_rr) q.push_back('{cycle_no + 2, ref_mem[ra]});
      if (exp_wr) ref_mem[wa] = wd;
      if (exp_wr) wv = 1'b0;
      if (exp_rr) rv = 1'b0;
    end
    cmp_count++;
    if (q.size() !== 0) begin
      err_count++;
      $display("[TB] FAIL rand_drain: got %0d outstanding reads want 0", q.size());
    end
    dp_w_valid = 1'b0;
    dp_r_valid = 1'b0;
  endtask

  initial begin
    cmp_count = 0;
    err_count = 0;
    test_reset();
    test_dp_write_wb_read();
    test_starvation();
    test_hazard();
    test_miss();
    test_partial_write();
    test_reset_mid_read();
    test_back_to_back();
    test_random_dp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
